writeback_arbiter: RTL and testbench
====================================

# writeback_arbiter

Write-side companion of the processor register file: merges single-cycle ALU results and variable-latency data-memory load returns into the register file's one write port. Load returns are buffered in a small FIFO and drained only in cycles with no ALU writeback. A per-register pending scoreboard lets decode stall on destination registers that still have a load in flight. Sits between execute/memory and the register file; its write outputs drive the register file's write enable, address and data inputs directly.

## Interface
- DEPTH, 4, load-return FIFO entries (power of two, 2..16)
- AW, 5, register address width
- DW, 32, data width
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result valid this cycle; never back-pressured
- alu_rd  in  AW  ALU destination register
- alu_data  in  DW  ALU result
- ld_issue  in  1  load issued to memory this cycle
- ld_issue_rd  in  AW  destination of issued load
- ld_valid  in  1  load data returning
- ld_ready  out  1  FIFO can accept; equals (count < DEPTH), combinational from registered count only
- ld_rd  in  AW  returning load destination
- ld_data  in  DW  returning load data
- wr_en  out  1  register file write enable (registered)
- wr_addr  out  AW  register file write address (registered)
- wr_data  out  DW  register file write data (registered)
- pending  out  2**AW  bit r set while a load to register r is outstanding; bit 0 always 0
- ld_count  out  clog2(DEPTH)+1  FIFO occupancy
- err  out  1  sticky protocol-violation flag

## Operation
- Priority each cycle: alu_valid, then FIFO head (if count > 0), else idle.
- ALU path: alu_valid at edge t loads wr_en=1, wr_addr=alu_rd, wr_data=alu_data.
- FIFO drain: with alu_valid low and count > 0, the head is popped into wr_* and the matching pending bit is cleared at the same edge.
- Push: ld_valid & ld_ready stores (ld_rd, ld_data) at the tail. A pushed entry is eligible for drain no earlier than the following edge; there is no FIFO bypass.
- Push and pop in the same edge: count is unchanged. With count == DEPTH, ld_ready stays 0 even if a pop occurs.
- Destination 0: wr_en is not asserted for alu_rd==0 or a head with ld_rd==0. The entry is still consumed, and the slot counts as an idle write cycle.
- Scoreboard: ld_issue with ld_issue_rd != 0 sets pending[ld_issue_rd]. A set and a clear of the same bit in one edge leaves the bit set.
- err is set and stays set until reset on any of:
  - ld_issue to a register whose pending bit is already 1;
  - alu_valid with pending[alu_rd]==1 and alu_rd != 0 (WAW against an in-flight load);
  - ld_valid with pending[ld_rd]==0 and ld_rd != 0.
- A violating event still performs its normal write or push.
- wr_en is deasserted on every edge that has no write selected.

## Timing
- Reset (async assert, released synchronously to clk by the system): wr_en=0, wr_addr=0, wr_data=0, pending=0, err=0, FIFO pointers and count=0, ld_ready=1.
- ALU latency: alu_valid at cycle t gives wr_en high during cycle t+1.
- Load latency, uncontended: push at edge t, wr_en high during cycle t+2, pending bit low from the edge ending cycle t+1.
- The register file captures the write on the negedge inside the wr_en cycle, so decode reading after that edge sees the new value.
- Each cycle with alu_valid high delays every queued load by one cycle. Queued loads drain in arrival order.
- Reset mid-operation: FIFO contents are discarded, pending bits are cleared and wr_en drops immediately.
- Pointer wrap-around is modulo DEPTH.

## Test plan
- Back-to-back ALU writes: alu_valid for 3 cycles to R1..R3 with data 0x11, 0x22, 0x33 -> wr_en high for 3 cycles, wr_addr 1,2,3 each one cycle after its input.
- Issue a load to R5, return 0xDEADBEEF 4 cycles later with no ALU traffic -> pending[5] goes 1 to 0, wr_en with wr_addr=5 exactly 2 cycles after the push, err=0.
- Fill: issue loads to R1..R4, hold alu_valid high, return all 4 -> ld_count=4 and ld_ready=0; a 5th ld_valid is not accepted; after alu_valid drops, writes R1..R4 occur in order on consecutive cycles.
- Push and pop in one cycle at count=2 -> count stays 2. Run 10 entries through DEPTH=4 and check pointer wrap preserves order and data.
- Destination R0: ALU write to R0 and a load return to R0 -> no wr_en; the FIFO entry is consumed and pending[0] stays 0.
- Violations: double ld_issue to R7, then assert rst_n low mid-drain with 3 entries queued -> err=1 after the second issue; on reset, wr_en=0, ld_count=0, pending=0, err=0.

Source files
------------

// File: rtl/writeback_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : writeback_arbiter_if
// Description : Bundle of execute/memory-side inputs and register-file-side
//               outputs of the writeback arbiter.
//               slave  : the arbiter (receives i_*, drives o_*)
//               master : the surrounding pipeline / testbench
// Ports       :
//   i_alu_valid/i_alu_rd/i_alu_data   ALU result, never back-pressured
//   i_ld_issue/i_ld_issue_rd          load issued to memory
//   i_ld_valid/i_ld_rd/i_ld_data      load return, accepted when o_ld_ready
//   o_ld_ready                        load FIFO has space
//   o_wr_en/o_wr_addr/o_wr_data       registered register-file write port
//   o_pending                         per-register load-in-flight bits
//   o_ld_count                        load FIFO occupancy
//   o_err                             sticky protocol-violation flag
// Revision    : 1.0 - initial release
// ============================================================================
interface writeback_arbiter_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int NREG = 1 << AW;

  logic            i_alu_valid;
  logic [AW-1:0]   i_alu_rd;
  logic [DW-1:0]   i_alu_data;
  logic            i_ld_issue;
  logic [AW-1:0]   i_ld_issue_rd;
  logic            i_ld_valid;
  logic            o_ld_ready;
  logic [AW-1:0]   i_ld_rd;
  logic [DW-1:0]   i_ld_data;
  logic            o_wr_en;
  logic [AW-1:0]   o_wr_addr;
  logic [DW-1:0]   o_wr_data;
  logic [NREG-1:0] o_pending;
  logic [CW-1:0]   o_ld_count;
  logic            o_err;

  modport slave (
    input  i_alu_valid, i_alu_rd, i_alu_data,
    input  i_ld_issue, i_ld_issue_rd,
    input  i_ld_valid, i_ld_rd, i_ld_data,
    output o_ld_ready,
    output o_wr_en, o_wr_addr, o_wr_data,
    output o_pending, o_ld_count, o_err
  );

  modport master (
    output i_alu_valid, i_alu_rd, i_alu_data,
    output i_ld_issue, i_ld_issue_rd,
    output i_ld_valid, i_ld_rd, i_ld_data,
    input  o_ld_ready,
    input  o_wr_en, o_wr_addr, o_wr_data,
    input  o_pending, o_ld_count, o_err
  );
endinterface : writeback_arbiter_if
`default_nettype wire

// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : writeback_arbiter
// Description : Merges single-cycle ALU results and buffered load returns onto
//               the single register-file write port. ALU results always win;
//               the load FIFO drains only in cycles without an ALU result.
//               Keeps a per-register pending scoreboard of in-flight loads and
//               a sticky error flag for protocol violations.
// Ports       :
//   clk    in  clock, all state on posedge
//   rst_n  in  asynchronous active-low reset
//   bus    writeback_arbiter_if.slave (see interface header)
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  writeback_arbiter_if.slave    bus
);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int NREG = 1 << AW;

  // FIFO storage and bookkeeping
  logic [AW-1:0]   r_fifo_rd   [DEPTH];
  logic [DW-1:0]   r_fifo_data [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  // Write port, scoreboard, error
  logic            r_wr_en;
  logic [AW-1:0]   r_wr_addr;
  logic [DW-1:0]   r_wr_data;
  logic [NREG-1:0] r_pending;
  logic            r_err;

  logic            w_ld_ready;
  logic            w_push;
  logic            w_pop;
  logic [AW-1:0]   w_head_rd;
  logic [DW-1:0]   w_head_data;
  logic [NREG-1:0] w_pending_nxt;
  logic            w_err_evt;

  // Ready depends on the registered count only, so a pop in the same cycle
  // never frees a slot early.
  assign w_ld_ready  = (r_count < CW'(DEPTH));
  assign w_push      = bus.i_ld_valid & w_ld_ready;
  assign w_pop       = ~bus.i_alu_valid & (r_count != '0);
  assign w_head_rd   = r_fifo_rd[r_rptr];
  assign w_head_data = r_fifo_data[r_rptr];

  // Scoreboard next state: clear on drain first, then set on issue so that a
  // simultaneous set and clear of the same bit leaves it set. Bit 0 is tied low.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_pop && (w_head_rd != '0)) begin
      w_pending_nxt[w_head_rd] = 1'b0;
    end
    if (bus.i_ld_issue && (bus.i_ld_issue_rd != '0)) begin
      w_pending_nxt[bus.i_ld_issue_rd] = 1'b1;
    end
    w_pending_nxt[0] = 1'b0;
  end

  // Violations are judged against the scoreboard as it stood before this edge.
  always_comb begin
    w_err_evt = 1'b0;
    if (bus.i_ld_issue && r_pending[bus.i_ld_issue_rd]) begin
      w_err_evt = 1'b1;
    end
    if (bus.i_alu_valid && (bus.i_alu_rd != '0) && r_pending[bus.i_alu_rd]) begin
      w_err_evt = 1'b1;
    end
    if (bus.i_ld_valid && (bus.i_ld_rd != '0) && !r_pending[bus.i_ld_rd]) begin
      w_err_evt = 1'b1;
    end
  end

  // FIFO payload needs no reset: only entries below r_count are ever read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wptr]   <= bus.i_ld_rd;
      r_fifo_data[r_wptr] <= bus.i_ld_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Write selection: ALU, else FIFO head, else idle. Destination 0 consumes
  // the slot without raising the enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (bus.i_alu_valid) begin
      r_wr_en   <= (bus.i_alu_rd != '0);
      r_wr_addr <= bus.i_alu_rd;
      r_wr_data <= bus.i_alu_data;
    end else if (w_pop) begin
      r_wr_en   <= (w_head_rd != '0);
      r_wr_addr <= w_head_rd;
      r_wr_data <= w_head_data;
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_err     <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_err_evt) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.o_ld_ready = w_ld_ready;
  assign bus.o_wr_en    = r_wr_en;
  assign bus.o_wr_addr  = r_wr_addr;
  assign bus.o_wr_data  = r_wr_data;
  assign bus.o_pending  = r_pending;
  assign bus.o_ld_count = r_count;
  assign bus.o_err      = r_err;

endmodule : writeback_arbiter
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_arbiter
// Description : Directed self-checking bench for writeback_arbiter. Expected
//               register-file writes are queued when stimulus is driven and
//               popped when the DUT raises the write enable.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_arbiter;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   vecs;
  int   fails;
  exp_t q[$];

  writeback_arbiter_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  writeback_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected write visible at the negedge sample taken when cyc == c
  // (c < 0: order only).
  task automatic expect_wr(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.cyc  = c;
    e.addr = a;
    e.data = d;
    q.push_back(e);
  endtask

  // Sample the write port on the negedge, then advance through one posedge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (rst_n) begin
      if (bus.o_wr_en) begin
        if (q.size() == 0) begin
          chk("wr_en_unexpected", 64'(bus.o_wr_en), 64'd0);
        end else begin
          e = q.pop_front();
          chk("wr_addr", 64'(bus.o_wr_addr), 64'(e.addr));
          chk("wr_data", 64'(bus.o_wr_data), 64'(e.data));
          if (e.cyc >= 0) chk("wr_cycle", 64'(cyc), 64'(e.cyc));
        end
      end else if (q.size() > 0 && q[0].cyc >= 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        chk("wr_en_missing", 64'(bus.o_wr_en), 64'd1);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle();
    bus.i_alu_valid   = 1'b0;
    bus.i_alu_rd      = '0;
    bus.i_alu_data    = '0;
    bus.i_ld_issue    = 1'b0;
    bus.i_ld_issue_rd = '0;
    bus.i_ld_valid    = 1'b0;
    bus.i_ld_rd       = '0;
    bus.i_ld_data     = '0;
  endtask

  initial begin
    logic [DW-1:0] wd;
    cyc   = 0;
    vecs  = 0;
    fails = 0;
    idle();
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_wr_en",    64'(bus.o_wr_en),    64'd0);
    chk("rst_wr_addr",  64'(bus.o_wr_addr),  64'd0);
    chk("rst_wr_data",  64'(bus.o_wr_data),  64'd0);
    chk("rst_pending",  64'(bus.o_pending),  64'd0);
    chk("rst_err",      64'(bus.o_err),      64'd0);
    chk("rst_ld_count", 64'(bus.o_ld_count), 64'd0);
    chk("rst_ld_ready", 64'(bus.o_ld_ready), 64'd1);
    rst_n = 1'b1;
    tick();

    // Back-to-back ALU writes R1..R3
    for (int i = 1; i <= 3; i++) begin
      bus.i_alu_valid = 1'b1;
      bus.i_alu_rd    = AW'(i);
      bus.i_alu_data  = DW'(i * 32'h11);
      expect_wr(cyc + 1, AW'(i), DW'(i * 32'h11));
      tick();
    end
    idle();
    repeat (2) tick();

    // Single uncontended load to R5
    bus.i_ld_issue    = 1'b1;
    bus.i_ld_issue_rd = 5'd5;
    tick();
    idle();
    chk("pend5_set", 64'(bus.o_pending[5]), 64'd1);
    repeat (3) tick();
    bus.i_ld_valid = 1'b1;
    bus.i_ld_rd    = 5'd5;
    bus.i_ld_data  = 32'hDEADBEEF;
    expect_wr(cyc + 2, 5'd5, 32'hDEADBEEF);
    tick();
    idle();
    chk("pend5_after_push", 64'(bus.o_pending[5]), 64'd1);
    chk("count_after_push", 64'(bus.o_ld_count), 64'd1);
    tick();
    chk("pend5_cleared", 64'(bus.o_pending[5]), 64'd0);
    chk("count_after_pop", 64'(bus.o_ld_count), 64'd0);
    repeat (2) tick();
    chk("err_single_load", 64'(bus.o_err), 64'd0);

    // Fill the FIFO while the ALU holds the write port
    for (int i = 0; i < 4; i++) begin
      bus.i_alu_valid   = 1'b1;
      bus.i_alu_rd      = 5'd10;
      bus.i_alu_data    = DW'(32'h100 + i);
      bus.i_ld_issue    = 1'b1;
      bus.i_ld_issue_rd = AW'(i + 1);
      expect_wr(cyc + 1, 5'd10, DW'(32'h100 + i));
      tick();
    end
    bus.i_ld_issue = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.i_alu_data = DW'(32'h200 + i);
      bus.i_ld_valid = 1'b1;
      bus.i_ld_rd    = AW'(i + 1);
      bus.i_ld_data  = DW'(32'hA1 + i);
      expect_wr(cyc + 1, 5'd10, DW'(32'h200 + i));
      tick();
    end
    chk("fill_count", 64'(bus.o_ld_count), 64'd4);
    chk("fill_ready", 64'(bus.o_ld_ready), 64'd0);
    bus.i_alu_data = 32'h300;
    bus.i_ld_rd    = 5'd4;
    bus.i_ld_data  = 32'h00000BAD;
    expect_wr(cyc + 1, 5'd10, 32'h300);
    tick();
    chk("fill_5th_rejected", 64'(bus.o_ld_count), 64'd4);
    idle();
    chk("full_ready_on_pop", 64'(bus.o_ld_ready), 64'd0);
    for (int i = 0; i < 4; i++) expect_wr(cyc + 1 + i, AW'(i + 1), DW'(32'hA1 + i));
    repeat (6) tick();
    chk("fill_drained_count", 64'(bus.o_ld_count), 64'd0);
    chk("fill_drained_pend", 64'(bus.o_pending), 64'd0);
    chk("fill_err", 64'(bus.o_err), 64'd0);

    // Push and pop in the same edge at count == 2
    for (int i = 11; i <= 13; i++) begin
      bus.i_ld_issue    = 1'b1;
      bus.i_ld_issue_rd = AW'(i);
      tick();
    end
    idle();
    for (int i = 0; i < 2; i++) begin
      bus.i_alu_valid = 1'b1;
      bus.i_alu_rd    = 5'd20;
      bus.i_alu_data  = DW'(32'h400 + i);
      bus.i_ld_valid  = 1'b1;
      bus.i_ld_rd     = AW'(11 + i);
      bus.i_ld_data   = DW'(32'hB11 + i);
      expect_wr(cyc + 1, 5'd20, DW'(32'h400 + i));
      tick();
    end
    chk("pp_count_before", 64'(bus.o_ld_count), 64'd2);
    bus.i_alu_valid = 1'b0;
    bus.i_ld_rd     = 5'd13;
    bus.i_ld_data   = 32'hB13;
    expect_wr(cyc + 1, 5'd11, 32'hB11);
    expect_wr(cyc + 2, 5'd12, 32'hB12);
    expect_wr(cyc + 3, 5'd13, 32'hB13);
    tick();
    chk("pp_count_same", 64'(bus.o_ld_count), 64'd2);
    idle();
    repeat (4) tick();
    chk("pp_count_end", 64'(bus.o_ld_count), 64'd0);

    // Ten entries streamed through the FIFO to exercise pointer wrap
    for (int i = 0; i <= 10; i++) begin
      idle();
      if (i < 10) begin
        bus.i_ld_issue    = 1'b1;
        bus.i_ld_issue_rd = AW'(16 + i);
      end
      if (i > 0) begin
        wd             = $urandom;
        bus.i_ld_valid = 1'b1;
        bus.i_ld_rd    = AW'(15 + i);
        bus.i_ld_data  = wd;
        expect_wr(cyc + 2, AW'(15 + i), wd);
      end
      tick();
    end
    idle();
    repeat (3) tick();
    chk("wrap_err", 64'(bus.o_err), 64'd0);
    chk("wrap_pend", 64'(bus.o_pending), 64'd0);

    // Destination R0: no write, entry still consumed
    bus.i_alu_valid = 1'b1;
    bus.i_alu_rd    = 5'd0;
    bus.i_alu_data  = 32'h55;
    tick();
    idle();
    bus.i_ld_valid = 1'b1;
    bus.i_ld_rd    = 5'd0;
    bus.i_ld_data  = 32'h66;
    tick();
    idle();
    chk("r0_count_push", 64'(bus.o_ld_count), 64'd1);
    tick();
    chk("r0_count_pop", 64'(bus.o_ld_count), 64'd0);
    chk("r0_pend0", 64'(bus.o_pending[0]), 64'd0);
    repeat (2) tick();
    chk("r0_err", 64'(bus.o_err), 64'd0);

    // Double issue to R7 raises err; then reset mid-drain
    bus.i_ld_issue    = 1'b1;
    bus.i_ld_issue_rd = 5'd7;
    tick();
    chk("err_first_issue", 64'(bus.o_err), 64'd0);
    tick();
    chk("err_double_issue", 64'(bus.o_err), 64'd1);
    idle();
    for (int i = 0; i < 6; i++) begin
      bus.i_alu_valid = 1'b1;
      bus.i_alu_rd    = 5'd20;
      bus.i_alu_data  = DW'(32'h500 + i);
      expect_wr(cyc + 1, 5'd20, DW'(32'h500 + i));
      bus.i_ld_issue  = (i < 3);
      bus.i_ld_issue_rd = AW'(8 + (i % 3));
      bus.i_ld_valid  = (i >= 3);
      bus.i_ld_rd     = AW'(8 + (i % 3));
      bus.i_ld_data   = DW'(32'hC8 + (i % 3));
      tick();
    end
    chk("mid_count3", 64'(bus.o_ld_count), 64'd3);
    idle();
    tick();
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("mid_rst_wr_en", 64'(bus.o_wr_en), 64'd0);
    chk("mid_rst_count", 64'(bus.o_ld_count), 64'd0);
    chk("mid_rst_pending", 64'(bus.o_pending), 64'd0);
    chk("mid_rst_err", 64'(bus.o_err), 64'd0);
    chk("mid_rst_ready", 64'(bus.o_ld_ready), 64'd1);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_wr_en", 64'(bus.o_wr_en), 64'd0);
    chk("post_rst_queue", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule : tb_writeback_arbiter
`default_nettype wire
